seg_scan_ndigit: RTL and testbench

Parametrised multiplexed 7-segment display driver for N digits of ASCII text. Each digit position gets a time slot, with a programmable dead band between slots to suppress ghosting. Display data is double-buffered and only applied at frame boundaries, so displayed text never tears. Per-digit decimal point and per-digit blink are supported. It sits between application logic that produces text and the board's segment and digit-select pins.

---
 rtl/seg_scan_ndigit.sv | 186 ++++++++++++++++++
 tb/tb_seg_scan_ndigit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_ndigit.sv
// Multiplexed N-digit 7-segment driver for ASCII text, with a blank dead band per slot,
// double-buffered display data swapped at frame boundaries, and per-digit dp and blink.
module seg_scan_ndigit #(
  parameter int unsigned p_system_clk      = 100_000_000,
  parameter int unsigned p_digits          = 8,
  parameter int unsigned p_scan_hz         = 1000,
  parameter int unsigned p_blank_cycles    = 4,
  parameter int unsigned p_blink_hz        = 2,
  parameter int unsigned p_pos_active_high = 1,
  parameter int unsigned p_seg_active_high = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*p_digits-1:0]   i_data,
  input  logic [p_digits-1:0]     i_dp,
  input  logic [p_digits-1:0]     i_blink_mask,
  input  logic                    i_load,
  output logic [p_digits-1:0]     o_seg_pos,
  output logic [7:0]              o_seg,
  output logic                    o_frame_done
);

  localparam int unsigned S  = p_system_clk / p_scan_hz;
  localparam int unsigned B  = p_system_clk / (2 * p_blink_hz);
  localparam int unsigned SW = (S > 1) ? $clog2(S) : 1;
  localparam int unsigned BW = (B > 1) ? $clog2(B) : 1;
  localparam int unsigned DW = (p_digits > 1) ? $clog2(p_digits) : 1;

  localparam logic [p_digits-1:0] POS_OFF = (p_pos_active_high != 0) ? '0 : '1;
  localparam logic [7:0]          SEG_OFF = (p_seg_active_high != 0) ? '0 : '1;
  localparam logic [8*p_digits-1:0] ALL_SPACES = {p_digits{8'h20}};

  logic [SW-1:0]           slot_q, slot_d;
  logic [DW-1:0]           digit_q, digit_d;
  logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;

  logic [8*p_digits-1:0]   act_data_q, act_data_d;
  logic [p_digits-1:0]     act_dp_q, act_dp_d;
  logic [p_digits-1:0]     act_blink_q, act_blink_d;
  logic [8*p_digits-1:0]   pend_data_q, pend_data_d;
  logic [p_digits-1:0]     pend_dp_q, pend_dp_d;
  logic [p_digits-1:0]     pend_blink_q, pend_blink_d;
  logic                    pend_valid_q, pend_valid_d;

  logic [p_digits-1:0]     seg_pos_q, seg_pos_d;
  logic [7:0]              seg_q, seg_d;
  logic                    frame_done_q, frame_done_d;

  logic                    slot_wrap;
  logic                    last_digit;
  logic [7:0]              cur_char;
  logic [p_digits-1:0]     pos_act;
  logic [7:0]              seg_act;

  function automatic logic [6:0] decode(input logic [7:0] ch);
    logic [6:0] g;
    case (ch)
      8'h30: g = 7'h3F;
      8'h31: g = 7'h06;
      8'h32: g = 7'h5B;
      8'h33: g = 7'h4F;
      8'h34: g = 7'h66;
      8'h35: g = 7'h6D;
      8'h36: g = 7'h7D;
      8'h37: g = 7'h07;
      8'h38: g = 7'h7F;
      8'h39: g = 7'h6F;
      8'h41, 8'h61: g = 7'h77;
      8'h42, 8'h62: g = 7'h7C;
      8'h43, 8'h63: g = 7'h39;
      8'h44, 8'h64: g = 7'h5E;
      8'h45, 8'h65: g = 7'h79;
      8'h46, 8'h66: g = 7'h71;
      8'h2D: g = 7'h40;
      8'h5F: g = 7'h08;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  always_comb begin
    slot_d        = slot_q;
    digit_d       = digit_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    act_data_d    = act_data_q;
    act_dp_d      = act_dp_q;
    act_blink_d   = act_blink_q;
    pend_data_d   = pend_data_q;
    pend_dp_d     = pend_dp_q;
    pend_blink_d  = pend_blink_q;
    pend_valid_d  = pend_valid_q;
    pos_act       = '0;
    seg_act       = '0;

    slot_wrap  = (slot_q == SW'(S - 1));
    last_digit = (digit_q == DW'(p_digits - 1));

    slot_d = slot_wrap ? '0 : slot_q + SW'(1);
    if (slot_wrap) begin
      digit_d = last_digit ? '0 : digit_q + DW'(1);
    end

    if (blink_cnt_q == BW'(B - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
    end

    if (i_load) begin
      pend_data_d  = i_data;
      pend_dp_d    = i_dp;
      pend_blink_d = i_blink_mask;
      pend_valid_d = 1'b1;
    end

    // The buffer swap is keyed to the registered o_frame_done cycle, so a load
    // coinciding with the visible pulse takes the bypass path into the new frame.
    if (frame_done_q) begin
      if (i_load) begin
        act_data_d   = i_data;
        act_dp_d     = i_dp;
        act_blink_d  = i_blink_mask;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        act_data_d   = pend_data_q;
        act_dp_d     = pend_dp_q;
        act_blink_d  = pend_blink_q;
        pend_valid_d = 1'b0;
      end
    end

    cur_char = act_data_q[{digit_q, 3'b000} +: 8];
    if (slot_q >= SW'(p_blank_cycles)) begin
      pos_act[digit_q] = 1'b1;
      if (!(blink_phase_q && act_blink_q[digit_q])) begin
        seg_act = {act_dp_q[digit_q], decode(cur_char)};
      end
    end

    seg_pos_d    = pos_act ^ POS_OFF;
    seg_d        = seg_act ^ SEG_OFF;
    frame_done_d = slot_wrap && last_digit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q        <= '0;
      digit_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      act_data_q    <= ALL_SPACES;
      act_dp_q      <= '0;
      act_blink_q   <= '0;
      pend_data_q   <= ALL_SPACES;
      pend_dp_q     <= '0;
      pend_blink_q  <= '0;
      pend_valid_q  <= 1'b0;
      seg_pos_q     <= POS_OFF;
      seg_q         <= SEG_OFF;
      frame_done_q  <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      digit_q       <= digit_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      act_data_q    <= act_data_d;
      act_dp_q      <= act_dp_d;
      act_blink_q   <= act_blink_d;
      pend_data_q   <= pend_data_d;
      pend_dp_q     <= pend_dp_d;
      pend_blink_q  <= pend_blink_d;
      pend_valid_q  <= pend_valid_d;
      seg_pos_q     <= seg_pos_d;
      seg_q         <= seg_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign o_seg_pos    = seg_pos_q;
  assign o_seg        = seg_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ndigit.sv
// Directed bench for seg_scan_ndigit: 4 digits, S=10, blank=2, B=20; every output
// cycle of each checked frame is compared against hand-computed glyphs.
module tb_seg_scan_ndigit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_data = '0;
  logic [3:0]  i_dp = '0;
  logic [3:0]  i_blink_mask = '0;
  logic        i_load = 1'b0;
  logic [3:0]  o_seg_pos;
  logic [7:0]  o_seg;
  logic        o_frame_done;

  int n_vec = 0;
  int n_err = 0;

  seg_scan_ndigit #(
    .p_system_clk(1000),
    .p_digits(4),
    .p_scan_hz(100),
    .p_blank_cycles(2),
    .p_blink_hz(25),
    .p_pos_active_high(1),
    .p_seg_active_high(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_data(i_data),
    .i_dp(i_dp),
    .i_blink_mask(i_blink_mask),
    .i_load(i_load),
    .o_seg_pos(o_seg_pos),
    .o_seg(o_seg),
    .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  dp;
    logic [3:0]  mask;
    logic        two;
    logic [31:0] first_data;
    logic [31:0] exp;   // byte k = raw glyph (with dp) for digit k
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int j, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s c=%0d got %h want %h", name, j, act, exp);
    end
  endtask

  // Entered in a cycle whose scan counter is 0 (a frame_done cycle or the first cycle
  // after reset); checks the 40 outputs of that frame and ends in the next frame_done cycle.
  task automatic run_frame(input logic [31:0] exp, input logic [3:0] mask,
                           input int at1, input logic [31:0] d1, input logic [3:0] dp1, input logic [3:0] m1,
                           input int at2, input logic [31:0] d2, input logic [3:0] dp2, input logic [3:0] m2);
    int d;
    int s;
    logic [7:0] e_pos;
    logic [7:0] e_seg;
    for (int j = 0; j < 40; j++) begin
      if (j == at1) begin
        i_data = d1; i_dp = dp1; i_blink_mask = m1; i_load = 1'b1;
      end else if (j == at2) begin
        i_data = d2; i_dp = dp2; i_blink_mask = m2; i_load = 1'b1;
      end
      @(posedge clk);
      #1;
      i_load = 1'b0;
      i_data = 32'hDEAD_BEEF;
      d = j / 10;
      s = j % 10;
      e_pos = '0;
      e_seg = '0;
      if (s >= 2) begin
        e_pos[d] = 1'b1;
        if (!(mask[d] && j >= 20)) e_seg = exp[8*d +: 8];
      end
      check("seg_pos", j, {4'b0, o_seg_pos}, e_pos);
      check("seg", j, o_seg, e_seg);
      check("frame_done", j, {7'b0, o_frame_done}, {7'b0, (j == 39)});
    end
  endtask

  initial begin
    logic [31:0] prev_exp;
    logic [3:0]  prev_mask;

    vecs[0] = '{data: "1234", dp: 4'b0000, mask: 4'b0000, two: 1'b0, first_data: '0, exp: 32'h065B4F66};
    vecs[1] = '{data: "-_8 ", dp: 4'b0000, mask: 4'b0000, two: 1'b1, first_data: "AAAA", exp: 32'h40087F00};
    vecs[2] = '{data: "9999", dp: 4'b0010, mask: 4'b0001, two: 1'b0, first_data: '0, exp: 32'h6F6FEF6F};
    vecs[3] = '{data: "9999", dp: 4'b0100, mask: 4'b1111, two: 1'b0, first_data: '0, exp: 32'h6FEF6F6F};
    vecs[4] = '{data: "aBcD", dp: 4'b1000, mask: 4'b0000, two: 1'b0, first_data: '0, exp: 32'hF77C395E};
    vecs[5] = '{data: "5 Zx", dp: 4'b0001, mask: 4'b0000, two: 1'b0, first_data: '0, exp: 32'h6D000080};
    vecs[6] = '{data: "7-6/", dp: 4'b0000, mask: 4'b0000, two: 1'b0, first_data: '0, exp: 32'h07407D00};
    vecs[7] = '{data: "e:Ff", dp: 4'b0000, mask: 4'b0000, two: 1'b0, first_data: '0, exp: 32'h79007171};

    // Reset state and an idle blank frame with frame_done 40 cycles after release.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_pos", 0, {4'b0, o_seg_pos}, 8'h00);
    check("rst_seg", 0, o_seg, 8'h00);
    check("rst_fd", 0, {7'b0, o_frame_done}, 8'h00);
    run_frame(32'h0, 4'h0, -1, '0, '0, '0, -1, '0, '0, '0);

    // Table: load mid-frame (old text stays up), then the following frame shows the new text.
    prev_exp = 32'h0;
    prev_mask = 4'h0;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].two)
        run_frame(prev_exp, prev_mask, 3, vecs[i].first_data, vecs[i].dp, vecs[i].mask,
                  17, vecs[i].data, vecs[i].dp, vecs[i].mask);
      else
        run_frame(prev_exp, prev_mask, 5, vecs[i].data, vecs[i].dp, vecs[i].mask,
                  -1, '0, '0, '0);
      run_frame(vecs[i].exp, vecs[i].mask, -1, '0, '0, '0, -1, '0, '0, '0);
      prev_exp = vecs[i].exp;
      prev_mask = vecs[i].mask;
    end

    // Load in the frame_done cycle itself is displayed in the very next frame.
    run_frame(32'h3F3F3F3F, 4'h0, 0, "0000", 4'h0, 4'h0, -1, '0, '0, '0);
    run_frame(32'h3F3F3F3F, 4'h0, -1, '0, '0, '0, -1, '0, '0, '0);

    // Reset during digit 2's on-phase together with a load: load is discarded.
    repeat (24) @(posedge clk);
    #1;
    rst = 1'b1;
    i_load = 1'b1;
    i_data = "8888";
    i_dp = 4'hF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_load = 1'b0;
    check("rst2_pos", 0, {4'b0, o_seg_pos}, 8'h00);
    check("rst2_seg", 0, o_seg, 8'h00);
    check("rst2_fd", 0, {7'b0, o_frame_done}, 8'h00);
    run_frame(32'h0, 4'h0, -1, '0, '0, '0, -1, '0, '0, '0);
    run_frame(32'h0, 4'h0, -1, '0, '0, '0, -1, '0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
